// File: rtl/gray_ctrl_pkg.sv
// Shared types and helpers for the gray counter run controller.
// FSM state encoding, default widths and the binary-to-gray conversion.
package gray_ctrl_pkg;

  localparam int GRAY_W    = 5;
  localparam int RUN_LEN_W = 8;
  localparam int CLR_CYC_D = 2;
  localparam int ERR_CNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Zero-extended input keeps every truncated result a valid gray code of the same width.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/gray_ref_cnt.sv
// Reference binary counter mirroring the gray counter under test.
// Exposes a registered gray-coded expected value.
module gray_ref_cnt
  import gray_ctrl_pkg::*;
#(
  parameter int WIDTH = GRAY_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] exp_gray_o
);

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q;

  always_comb begin
    bin_d = clr_i ? '0 : bin_q + WIDTH'(en_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      gray_q <= '0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= WIDTH'(bin2gray(32'(bin_d)));
    end
  end

  assign exp_gray_o = gray_q;

endmodule

// File: rtl/gray_run_ctrl.sv
// Sequencer/checker for the gray counter: clear, run for run_len counts, compare.
// Define GRAY_CTRL_ERR_STOP_EN to abort a run on the first RUN mismatch (adds port aborted).
module gray_run_ctrl
  import gray_ctrl_pkg::*;
#(
  parameter int WIDTH   = GRAY_W,
  parameter int LEN_W   = RUN_LEN_W,
  parameter int CLR_CYC = CLR_CYC_D,
  parameter int ERRC_W  = ERR_CNT_W
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              start,
  input  logic [LEN_W-1:0]  run_len,
  input  logic              hold,
  input  logic [WIDTH-1:0]  gray_in,
  output logic              cnt_reset_L,
  output logic              cnt_enable,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ERRC_W-1:0] err_count,
  output logic [WIDTH-1:0]  exp_gray
`ifdef GRAY_CTRL_ERR_STOP_EN
  ,
  output logic              aborted
`endif
);

  localparam int CLR_W = $clog2(CLR_CYC + 1);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  remain_q, remain_d;
  logic [CLR_W-1:0]  clr_q, clr_d;
  logic              first_q, first_d;
  logic              cnt_reset_L_q, cnt_reset_L_d;
  logic              cnt_enable_q, cnt_enable_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [ERRC_W-1:0] errc_q, errc_d;
  logic [WIDTH-1:0]  exp_gray_w;
  logic              start_ok, chk, mis, stop_w;

  gray_ref_cnt #(.WIDTH(WIDTH)) u_ref (
    .clk        (clk),
    .rst_n      (reset_L),
    .clr_i      (start_ok),
    .en_i       (cnt_enable_q),
    .exp_gray_o (exp_gray_w)
  );

  assign start_ok = (state_q == ST_IDLE) && start;
  // The RUN entry cycle repeats the reset value seen in the first enabled cycle, so it is skipped.
  assign chk = ((state_q == ST_RUN) && !first_q) || (state_q == ST_DRAIN);
  assign mis = chk && (gray_in != exp_gray_w);

`ifdef GRAY_CTRL_ERR_STOP_EN
  logic aborted_q;

  assign stop_w = (state_q == ST_RUN) && mis;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L)      aborted_q <= 1'b0;
    else if (start_ok) aborted_q <= 1'b0;
    else if (stop_w)   aborted_q <= 1'b1;
  end

  assign aborted = aborted_q;
`else
  assign stop_w = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    remain_d      = remain_q;
    clr_d         = clr_q;
    first_d       = first_q;
    cnt_reset_L_d = cnt_reset_L_q;
    cnt_enable_d  = cnt_enable_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    err_d         = err_q;
    errc_d        = errc_q;

    case (state_q)
      ST_IDLE: begin
        cnt_reset_L_d = 1'b0;
        cnt_enable_d  = 1'b0;
        if (start) begin
          remain_d = run_len;
          err_d    = 1'b0;
          errc_d   = '0;
          busy_d   = 1'b1;
          clr_d    = '0;
          state_d  = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        cnt_reset_L_d = 1'b0;
        if (clr_q == CLR_W'(CLR_CYC - 1)) begin
          cnt_reset_L_d = 1'b1;
          first_d       = 1'b1;
          state_d       = ST_RUN;
        end else begin
          clr_d = clr_q + 1'b1;
        end
      end
      ST_RUN: begin
        first_d = 1'b0;
        if (stop_w || remain_q == '0) begin
          cnt_enable_d = 1'b0;
          state_d      = ST_DRAIN;
        end else if (hold) begin
          cnt_enable_d = 1'b0;
        end else begin
          cnt_enable_d = 1'b1;
          remain_d     = remain_q - 1'b1;
        end
      end
      ST_DRAIN: begin
        cnt_enable_d = 1'b0;
        done_d       = 1'b1;
        busy_d       = 1'b0;
        state_d      = ST_DONE;
      end
      ST_DONE: begin
        cnt_reset_L_d = 1'b0;
        state_d       = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (mis) begin
      err_d = 1'b1;
      if (errc_q != '1) errc_d = errc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q       <= ST_IDLE;
      remain_q      <= '0;
      clr_q         <= '0;
      first_q       <= 1'b0;
      cnt_reset_L_q <= 1'b0;
      cnt_enable_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      errc_q        <= '0;
    end else begin
      state_q       <= state_d;
      remain_q      <= remain_d;
      clr_q         <= clr_d;
      first_q       <= first_d;
      cnt_reset_L_q <= cnt_reset_L_d;
      cnt_enable_q  <= cnt_enable_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
      errc_q        <= errc_d;
    end
  end

  assign cnt_reset_L = cnt_reset_L_q;
  assign cnt_enable  = cnt_enable_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign err_count   = errc_q;
  assign exp_gray    = exp_gray_w;

endmodule

// File: tb/tb_gray_run_ctrl.sv
// Directed bench for gray_run_ctrl with a behavioural gray counter attached.
module tb_gray_run_ctrl;

  logic       clk = 1'b0;
  logic       reset_L = 1'b0;
  logic       start = 1'b0;
  logic [7:0] run_len = 8'd0;
  logic       hold = 1'b0;
  logic [4:0] gray_in;
  logic       cnt_reset_L, cnt_enable, busy, done, err;
  logic [7:0] err_count;
  logic [4:0] exp_gray;
`ifdef GRAY_CTRL_ERR_STOP_EN
  logic       aborted;
`endif

  logic       stuck = 1'b0;
  logic [4:0] cbin;
  int         en_total = 0;
  int         checks = 0;
  int         failures = 0;

  gray_run_ctrl dut (
    .clk         (clk),
    .reset_L     (reset_L),
    .start       (start),
    .run_len     (run_len),
    .hold        (hold),
    .gray_in     (gray_in),
    .cnt_reset_L (cnt_reset_L),
    .cnt_enable  (cnt_enable),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .err_count   (err_count),
    .exp_gray    (exp_gray)
`ifdef GRAY_CTRL_ERR_STOP_EN
    ,
    .aborted     (aborted)
`endif
  );

  always #5 clk = ~clk;

  // Counter under test: registered binary count, gray output, optional bit0 stuck-at-1.
  always @(posedge clk or negedge cnt_reset_L) begin
    if (!cnt_reset_L)   cbin <= 5'd0;
    else if (cnt_enable) cbin <= cbin + 5'd1;
  end

  always_comb gray_in = (cbin ^ (cbin >> 1)) | {4'b0000, stuck};

  always @(posedge clk) en_total <= en_total + int'(cnt_enable);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // k==0 is the start edge; hold is applied for edges hs..hs+hc-1; es injects a second start.
  task automatic run_seq(input int len, input int hs, input int hc, input int es,
                         output int lat, output int en);
    int k;
    int base;
    base = en_total;
    k = 0;
    do begin
      start   = (k == 0) || (k == es);
      run_len = (k == es && k != 0) ? 8'd50 : 8'(len);
      hold    = (k >= hs) && (k < hs + hc);
      tick();
      k++;
    end while (done !== 1'b1 && k < 400);
    start = 1'b0;
    hold  = 1'b0;
    lat   = k - 1;
    en    = en_total - base;
  endtask

  task automatic test_reset();
    reset_L = 1'b0;
    repeat (3) tick();
    checks++; if (cnt_reset_L !== 1'b0) begin failures++; $display("FAIL rst_cnt_reset_L got=%b want=0", cnt_reset_L); end
    checks++; if (cnt_enable !== 1'b0) begin failures++; $display("FAIL rst_cnt_enable got=%b want=0", cnt_enable); end
    checks++; if ({busy, done, err} !== 3'b000) begin failures++; $display("FAIL rst_status got=%b want=000", {busy, done, err}); end
    checks++; if (err_count !== 8'd0) begin failures++; $display("FAIL rst_err_count got=%0d want=0", err_count); end
    checks++; if (exp_gray !== 5'd0) begin failures++; $display("FAIL rst_exp_gray got=%b want=00000", exp_gray); end
`ifdef GRAY_CTRL_ERR_STOP_EN
    checks++; if (aborted !== 1'b0) begin failures++; $display("FAIL rst_aborted got=%b want=0", aborted); end
`endif
    reset_L = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int lat, en;
    start = 1'b1; run_len = 8'd10;
    tick();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_after_start got=%b want=1", busy); end
    start = 1'b0;
    repeat (2) tick();
    checks++; if (cnt_reset_L !== 1'b1 || cnt_enable !== 1'b0) begin failures++; $display("FAIL basic_run_entry got=%b%b want=10", cnt_reset_L, cnt_enable); end
    tick();
    checks++; if (cnt_enable !== 1'b1) begin failures++; $display("FAIL basic_first_enable got=%b want=1", cnt_enable); end
    while (done !== 1'b1 && en_total < 100000) tick();
    reset_L = 1'b0; #1; reset_L = 1'b1;
    tick();
    run_seq(10, -1, 0, -1, lat, en);
    checks++; if (lat !== 14) begin failures++; $display("FAIL basic_latency got=%0d want=14", lat); end
    checks++; if (en !== 10) begin failures++; $display("FAIL basic_enables got=%0d want=10", en); end
    checks++; if (exp_gray !== 5'b01111 || gray_in !== 5'b01111) begin failures++; $display("FAIL basic_final_gray got=%b/%b want=01111", exp_gray, gray_in); end
    checks++; if (err !== 1'b0 || err_count !== 8'd0) begin failures++; $display("FAIL basic_err got=%b/%0d want=0/0", err, err_count); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_at_done got=%b want=0", busy); end
    tick();
    checks++; if (done !== 1'b0 || cnt_reset_L !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got=%b%b want=00", done, cnt_reset_L); end
  endtask

  task automatic test_wrap();
    int lat, en;
    run_seq(40, -1, 0, -1, lat, en);
    checks++; if (lat !== 44) begin failures++; $display("FAIL wrap_latency got=%0d want=44", lat); end
    checks++; if (en !== 40) begin failures++; $display("FAIL wrap_enables got=%0d want=40", en); end
    checks++; if (exp_gray !== 5'b01100 || gray_in !== 5'b01100) begin failures++; $display("FAIL wrap_final_gray got=%b/%b want=01100", exp_gray, gray_in); end
    checks++; if (err !== 1'b0 || err_count !== 8'd0) begin failures++; $display("FAIL wrap_err got=%b/%0d want=0/0", err, err_count); end
    tick();
  endtask

  task automatic test_hold();
    int lat, en;
    run_seq(5, 4, 3, -1, lat, en);
    checks++; if (lat !== 12) begin failures++; $display("FAIL hold_latency got=%0d want=12", lat); end
    checks++; if (en !== 5) begin failures++; $display("FAIL hold_enables got=%0d want=5", en); end
    checks++; if (exp_gray !== 5'b00111 || err !== 1'b0) begin failures++; $display("FAIL hold_final got=%b err=%b want=00111 err=0", exp_gray, err); end
    tick();
  endtask

  task automatic test_fault();
    int lat, en;
    stuck = 1'b1;
    run_seq(6, -1, 0, -1, lat, en);
    stuck = 1'b0;
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL fault_err got=%b want=1", err); end
`ifdef GRAY_CTRL_ERR_STOP_EN
    checks++; if (aborted !== 1'b1) begin failures++; $display("FAIL fault_aborted got=%b want=1", aborted); end
    checks++; if (en !== 1) begin failures++; $display("FAIL fault_enables got=%0d want=1", en); end
    checks++; if (err_count !== 8'd1) begin failures++; $display("FAIL fault_err_count got=%0d want=1", err_count); end
    checks++; if (lat !== 5) begin failures++; $display("FAIL fault_latency got=%0d want=5", lat); end
`else
    checks++; if (en !== 6) begin failures++; $display("FAIL fault_enables got=%0d want=6", en); end
    checks++; if (err_count !== 8'd3) begin failures++; $display("FAIL fault_err_count got=%0d want=3", err_count); end
    checks++; if (lat !== 10) begin failures++; $display("FAIL fault_latency got=%0d want=10", lat); end
`endif
    tick();
  endtask

  task automatic test_zero_busy();
    int lat, en;
    run_seq(0, -1, 0, -1, lat, en);
    checks++; if (lat !== 4) begin failures++; $display("FAIL zero_latency got=%0d want=4", lat); end
    checks++; if (en !== 0) begin failures++; $display("FAIL zero_enables got=%0d want=0", en); end
    checks++; if (err !== 1'b0 || err_count !== 8'd0) begin failures++; $display("FAIL zero_err_cleared got=%b/%0d want=0/0", err, err_count); end
`ifdef GRAY_CTRL_ERR_STOP_EN
    checks++; if (aborted !== 1'b0) begin failures++; $display("FAIL zero_aborted_cleared got=%b want=0", aborted); end
`endif
    tick();
    // hold with the start edge is ignored; the second start in CLEAR is ignored
    run_seq(3, 0, 1, 2, lat, en);
    checks++; if (lat !== 7) begin failures++; $display("FAIL busy_latency got=%0d want=7", lat); end
    checks++; if (en !== 3) begin failures++; $display("FAIL busy_enables got=%0d want=3", en); end
    tick();
  endtask

  task automatic test_reset_mid();
    int lat, en;
    start = 1'b1; run_len = 8'd20;
    tick();
    start = 1'b0;
    repeat (5) tick();
    checks++; if (cnt_enable !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL midrst_pre got=%b%b want=11", cnt_enable, busy); end
    reset_L = 1'b0;
    #1;
    checks++; if (cnt_reset_L !== 1'b0 || cnt_enable !== 1'b0) begin failures++; $display("FAIL midrst_cnt got=%b%b want=00", cnt_reset_L, cnt_enable); end
    checks++; if ({busy, done, err} !== 3'b000 || err_count !== 8'd0) begin failures++; $display("FAIL midrst_status got=%b/%0d want=000/0", {busy, done, err}, err_count); end
    checks++; if (exp_gray !== 5'd0) begin failures++; $display("FAIL midrst_exp_gray got=%b want=00000", exp_gray); end
    tick();
    reset_L = 1'b1;
    tick();
    run_seq(4, -1, 0, -1, lat, en);
    checks++; if (lat !== 8 || en !== 4) begin failures++; $display("FAIL midrst_rerun got=lat%0d/en%0d want=lat8/en4", lat, en); end
    checks++; if (exp_gray !== 5'b00110 || err !== 1'b0) begin failures++; $display("FAIL midrst_rerun_gray got=%b err=%b want=00110 err=0", exp_gray, err); end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_hold();
    test_fault();
    test_zero_busy();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
